// File: rtl/horner_digit_extract.sv
// Splits an unsigned value into base-radix digits, LSB first, using one restoring-division bit per clock.
// Optional macro HORNER_EARLY_TERM_EN: when set, a dividend already below the radix skips the division loop.
module horner_digit_extract #(
    parameter int WIDTH   = 32,
    parameter int RADIX_W = 8,
    parameter int IDX_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_value,
    input  logic [RADIX_W-1:0] in_radix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADIX_W-1:0] out_digit,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_last,
    output logic               out_err
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIV, EMIT} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   quotient;
    logic [RADIX_W-1:0] radix;
    logic [RADIX_W-1:0] remainder;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   index;
    logic               err;

    logic [RADIX_W:0]   trial;
    logic               trial_ge;
    logic [RADIX_W-1:0] remainder_next;
    logic               last_flag;
    logic               early;

    // Remainder stays below the radix, so trial - radix always fits back into RADIX_W bits.
    assign trial          = {remainder, dividend[WIDTH-1]};
    assign trial_ge       = trial >= {1'b0, radix};
    assign remainder_next = trial_ge ? RADIX_W'(trial - {1'b0, radix}) : RADIX_W'(trial);
    assign last_flag      = err || (quotient == '0);

`ifdef HORNER_EARLY_TERM_EN
    assign early = (bit_cnt == CNT_START) &&
                   (dividend < {{(WIDTH-RADIX_W){1'b0}}, radix});
`else
    assign early = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_digit = out_valid ? remainder : '0;
    assign out_index = out_valid ? index : '0;
    assign out_last  = out_valid && last_flag;
    assign out_err   = out_valid && err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (in_radix < RADIX_W'(2)) ? EMIT : DIV;
            DIV:  if (early || bit_cnt == '0) state_next = EMIT;
            EMIT: if (out_ready) state_next = last_flag ? IDLE : DIV;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an aborted request leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend  <= '0;
            quotient  <= '0;
            radix     <= '0;
            remainder <= '0;
            bit_cnt   <= '0;
            index     <= '0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            case (state)
                IDLE: if (in_valid) begin
                    dividend  <= in_value;
                    radix     <= in_radix;
                    quotient  <= '0;
                    remainder <= '0;
                    bit_cnt   <= CNT_START;
                    index     <= '0;
                    err       <= (in_radix < RADIX_W'(2));
                end
                DIV: if (early) begin
                    remainder <= dividend[RADIX_W-1:0];
                    quotient  <= '0;
                end else begin
                    remainder <= remainder_next;
                    quotient  <= {quotient[WIDTH-2:0], trial_ge};
                    dividend  <= {dividend[WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - 1'b1;
                end
                EMIT: if (out_ready) begin
                    if (last_flag) begin
                        err <= 1'b0;
                    end else begin
                        dividend  <= quotient;
                        quotient  <= '0;
                        remainder <= '0;
                        bit_cnt   <= CNT_START;
                        index     <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_horner_digit_extract.sv
// Scoreboard bench: expected digits come from plain % and / arithmetic; a monitor checks every presented beat.
module tb_horner_digit_extract;
    localparam int WIDTH   = 32;
    localparam int RADIX_W = 8;
    localparam int IDX_W   = 6;
    localparam int BOUND   = 4000;

    typedef struct packed {
        logic [RADIX_W-1:0] digit;
        logic [IDX_W-1:0]   index;
        logic               last;
        logic               err;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_value = '0;
    logic [RADIX_W-1:0] in_radix = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [RADIX_W-1:0] out_digit;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;
    logic               out_err;

    beat_t q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    bp_mode = 0;  // 0: always ready, 1: random ready, 2: stimulus drives out_ready

    horner_digit_extract #(.WIDTH(WIDTH), .RADIX_W(RADIX_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_radix(in_radix),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_index(out_index), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decompose by repeated division with ordinary integer arithmetic.
    task automatic model(input logic [WIDTH-1:0] value, input int radix);
        longint unsigned v = value;
        int idx = 0;
        beat_t b;
        if (radix < 2) begin
            b = '{digit: '0, index: '0, last: 1'b1, err: 1'b1};
            q.push_back(b);
            return;
        end
        do begin
            b.digit = RADIX_W'(v % radix);
            b.index = IDX_W'(idx);
            b.last  = (v / radix) == 0;
            b.err   = 1'b0;
            q.push_back(b);
            v = v / radix;
            idx++;
        end while (v != 0);
    endtask

    // Monitor: every presented beat must equal the scoreboard head; it is consumed only on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got digit %0d index %0d with empty scoreboard", out_digit, out_index);
            end else begin
                check("beat {digit,index,last,err}", 64'({out_digit, out_index, out_last, out_err}), 64'(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode == 0)      out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [WIDTH-1:0] value, input logic [RADIX_W-1:0] radix);
        int n = 0;
        model(value, int'(radix));
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_value = value;
        in_radix = radix;
        @(negedge clk);
        while (!in_ready && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) check("accept_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) check("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        int lat;
        int n;
        #2;
        check("reset in_ready/outputs", 64'({in_ready, out_valid, out_digit, out_index, out_last, out_err}),
              64'({1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0}));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'(1));

        // 1234 base 10 with first-digit latency: accept edge plus WIDTH division edges.
        send(32'd1234, 8'd10);
        lat = 1;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < BOUND) begin @(posedge clk); lat++; @(negedge clk); n++; end
        check("first digit latency", 64'(lat), 64'(WIDTH + 1));
        wait_idle();

        // Zero value: one beat, then idle on the following cycle.
        send(32'd0, 8'd10);
        wait(q.size() == 0);
        @(negedge clk);
        check("in_ready after zero", 64'(in_ready), 64'(1));

        send(32'hFFFF_FFFF, 8'd2);
        wait_idle();

        // Backpressure: first digit of 255 base 16 held for 5 cycles.
        bp_mode = 2;
        out_ready = 1'b0;
        send(32'd255, 8'd16);
        n = 0;
        while (!out_valid && n < BOUND) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("held digit", 64'({out_valid, out_digit, out_index}), 64'({1'b1, 8'd15, 6'd0}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        bp_mode = 0;

        send(32'd77, 8'd1);
        wait_idle();
        send(32'd77, 8'd0);
        wait_idle();

        // Reset in the middle of a division aborts the request.
        send(32'd1234, 8'd10);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-op reset outputs", 64'({in_ready, out_valid, out_digit, out_index, out_last, out_err}),
              64'({1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0}));
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        send(32'd5, 8'd10);
        wait_idle();

        // Random requests under random backpressure.
        bp_mode = 1;
        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0]   v;
            logic [RADIX_W-1:0] r;
            int sel;
            v = $urandom >> $urandom_range(0, 31);
            sel = $urandom_range(0, 9);
            if (sel == 0)      r = RADIX_W'($urandom_range(0, 1));
            else if (sel == 1) r = 8'd2;
            else               r = RADIX_W'($urandom_range(3, 255));
            send(v, r);
            wait_idle();
        end
        bp_mode = 0;
        repeat (3) @(negedge clk);
        check("scoreboard empty", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
